// File: rtl/adc_spi_pkg.sv
// Shared constants for the emulated 8-channel 12-bit serial ADC.
package adc_spi_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned LEAD_ZEROS = 4;
    localparam int unsigned ADDR_W     = 3;

    // Counter values (before increment) at which DIN carries address bits 2/1/0
    localparam int unsigned ADDR_POS2 = 2;
    localparam int unsigned ADDR_POS1 = 3;
    localparam int unsigned ADDR_POS0 = 4;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer that flags rising and falling edges of the synchronized signal.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise_c =  sync[SYNC_STAGES-1] & ~prev;
    assign fall_c = ~sync[SYNC_STAGES-1] &  prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI-side emulation of the serial ADC: decodes the channel address from DIN and
// shifts out the sample of the previously addressed channel on DOUT.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSCLK,
    input  logic              iCS_n,
    input  logic              iDIN,
    output logic              oDOUT,
    output logic              oDOUT_OE,
    output logic [2:0]        oCH,
    input  logic [DATA_W-1:0] iSAMPLE,
    output logic [2:0]        oRX_ADDR,
    output logic              oFRAME_DONE,
    output logic              oFRAME_ERR
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   din_s;

    logic [0:0]            state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [FRAME_BITS-1:0] shreg, shreg_n;
    logic [ADDR_W-1:0]     addr_next, addr_next_n;
    logic [2:0]            ch_n, rx_addr_n;
    logic                  oe_n, done_n, err_n;
    logic                  complete;
    logic [FRAME_BITS-1:0] load_word;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .clk(iCLK), .rst_n(iRST), .d(iSCLK), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(iCLK), .rst_n(iRST), .d(iCS_n), .rise_c(cs_rise), .fall_c(cs_fall)
    );

    // DIN only needs its level, aligned with the SCLK edge detect
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) din_sync <= '0;
        else       din_sync <= {din_sync[SYNC_STAGES-2:0], iDIN};
    end
    assign din_s = din_sync[SYNC_STAGES-1];

    assign load_word = FRAME_BITS'(iSAMPLE);
    assign oDOUT     = shreg[FRAME_BITS-1];

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            addr_next   <= '0;
            oCH         <= '0;
            oRX_ADDR    <= '0;
            oDOUT_OE    <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oFRAME_ERR  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            addr_next   <= addr_next_n;
            oCH         <= ch_n;
            oRX_ADDR    <= rx_addr_n;
            oDOUT_OE    <= oe_n;
            oFRAME_DONE <= done_n;
            oFRAME_ERR  <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        addr_next_n = addr_next;
        ch_n        = oCH;
        rx_addr_n   = oRX_ADDR;
        oe_n        = oDOUT_OE;
        done_n      = 1'b0;
        err_n       = 1'b0;
        complete    = (state == ACTIVE) && sclk_rise && (cnt == CNT_W'(FRAME_BITS - 1));

        // Completion takes priority over a simultaneous CS_n rise
        if (complete) begin
            ch_n      = addr_next;
            rx_addr_n = addr_next;
            done_n    = 1'b1;
        end

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n = ACTIVE;
                    cnt_n   = '0;
                    shreg_n = load_word;
                    oe_n    = 1'b1;
                end
            end
            default: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    shreg_n = '0;
                    oe_n    = 1'b0;
                    err_n   = !complete && (cnt != '0) && (cnt != CNT_W'(FRAME_BITS));
                end else begin
                    if (sclk_rise && (cnt != CNT_W'(FRAME_BITS))) begin
                        if (cnt == CNT_W'(ADDR_POS2)) addr_next_n[2] = din_s;
                        if (cnt == CNT_W'(ADDR_POS1)) addr_next_n[1] = din_s;
                        if (cnt == CNT_W'(ADDR_POS0)) addr_next_n[0] = din_s;
                        cnt_n = cnt + CNT_W'(1);
                    end
                    // The leading fall after CS_n keeps the MSB so the master sees all bits on its rises
                    if (sclk_fall) begin
                        if (cnt == CNT_W'(FRAME_BITS)) begin
                            shreg_n = load_word;
                            cnt_n   = '0;
                        end else if (cnt != '0) begin
                            shreg_n = {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench: acts as SPI master and per-channel sample source for adc_spi_responder.
module tb_adc_spi_responder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk  = 1'b1;
    logic        cs_n  = 1'b1;
    logic        din   = 1'b0;
    logic        dout, dout_oe, frame_done, frame_err;
    logic [2:0]  ch, rx_addr;
    logic [11:0] sample;
    logic [11:0] samp_tbl [8];

    int checks = 0;
    int passed = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always #5 clk = ~clk;

    assign sample = samp_tbl[ch];

    adc_spi_responder dut (
        .iCLK(clk), .iRST(rst_n), .iSCLK(sclk), .iCS_n(cs_n), .iDIN(din),
        .oDOUT(dout), .oDOUT_OE(dout_oe), .oCH(ch), .iSAMPLE(sample),
        .oRX_ADDR(rx_addr), .oFRAME_DONE(frame_done), .oFRAME_ERR(frame_err)
    );

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master clocks n bits, presenting the address on bits 3..5 and capturing DOUT before each rise
    task automatic clock_bits(input logic [2:0] addr, input int n, input int ratio,
                              output logic [15:0] cap);
        int lo;
        int hi;
        lo  = ratio - ratio / 2;
        hi  = ratio / 2;
        cap = '0;
        for (int k = 1; k <= n; k++) begin
            sclk = 1'b0;
            din  = (k == 3) ? addr[2] : (k == 4) ? addr[1] : (k == 5) ? addr[0] : 1'b0;
            wait_clk(lo);
            cap  = {cap[14:0], dout};
            sclk = 1'b1;
            wait_clk(hi);
        end
    endtask

    task automatic full_frame(input logic [2:0] addr, input int ratio, output logic [15:0] cap);
        cs_n = 1'b0;
        wait_clk(4);
        clock_bits(addr, 16, ratio, cap);
        cs_n = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        logic [15:0] cap, cap2;
        int          d0, e0;
        logic [2:0]  prev;
        logic [2:0]  sweep_addr [3];
        int          ratios [3];

        samp_tbl[0] = 12'hABC; samp_tbl[1] = 12'h5A5; samp_tbl[2] = 12'h3C7; samp_tbl[3] = 12'hF0E;
        samp_tbl[4] = 12'h777; samp_tbl[5] = 12'h123; samp_tbl[6] = 12'h8D1; samp_tbl[7] = 12'h0FF;

        wait_clk(3);
        check("rst_outputs", 32'({dout, dout_oe, ch, rx_addr, frame_done, frame_err}), 32'h0);
        rst_n = 1'b1;
        wait_clk(4);

        // Address 5, first frame returns ch0
        d0 = done_cnt; e0 = err_cnt;
        cs_n = 1'b0;
        wait_clk(4);
        check("oe_on", 32'(dout_oe), 32'h1);
        clock_bits(3'd5, 16, 8, cap);
        cs_n = 1'b1;
        wait_clk(6);
        check("f1_dout", 32'(cap), 32'h0ABC);
        check("f1_done", 32'(done_cnt - d0), 32'h1);
        check("f1_ch", 32'(ch), 32'h5);
        check("f1_rx", 32'(rx_addr), 32'h5);
        check("oe_off", 32'(dout_oe), 32'h0);

        // Address 2, returns ch5
        full_frame(3'd2, 8, cap);
        check("f2_dout", 32'(cap), 32'h0123);
        check("f2_ch", 32'(ch), 32'h2);

        // Abort after 9 SCLK cycles
        d0 = done_cnt;
        cs_n = 1'b0;
        wait_clk(4);
        clock_bits(3'd6, 9, 8, cap);
        cs_n = 1'b1;
        wait_clk(6);
        check("abort_err", 32'(err_cnt - e0), 32'h1);
        check("abort_done", 32'(done_cnt - d0), 32'h0);
        check("abort_ch", 32'(ch), 32'h2);
        check("abort_rx", 32'(rx_addr), 32'h2);
        full_frame(3'd1, 8, cap);
        check("post_abort_dout", 32'(cap), 32'h03C7);
        check("post_abort_ch", 32'(ch), 32'h1);

        // Continuous mode: 32 SCLK with CS_n low
        d0 = done_cnt;
        cs_n = 1'b0;
        wait_clk(4);
        clock_bits(3'd3, 16, 8, cap);
        clock_bits(3'd7, 16, 8, cap2);
        cs_n = 1'b1;
        wait_clk(6);
        check("cont_dout1", 32'(cap), 32'h05A5);
        check("cont_dout2", 32'(cap2), 32'h0F0E);
        check("cont_done", 32'(done_cnt - d0), 32'h2);
        check("cont_ch", 32'(ch), 32'h7);

        // Reset mid-frame
        cs_n = 1'b0;
        wait_clk(4);
        clock_bits(3'd4, 8, 8, cap);
        rst_n = 1'b0;
        wait_clk(2);
        check("midrst_outputs", 32'({dout, dout_oe, ch, rx_addr, frame_done, frame_err}), 32'h0);
        cs_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        full_frame(3'd6, 8, cap);
        check("post_rst_dout", 32'(cap), 32'h0ABC);
        check("post_rst_ch", 32'(ch), 32'h6);

        // Ratio sweep with fresh sample values
        samp_tbl[6] = 12'h4E2; samp_tbl[4] = 12'hC39; samp_tbl[1] = 12'h1F0; samp_tbl[7] = 12'h9AB;
        sweep_addr[0] = 3'd4; sweep_addr[1] = 3'd1; sweep_addr[2] = 3'd7;
        ratios[0] = 8; ratios[1] = 9; ratios[2] = 16;
        e0   = err_cnt;
        prev = 3'd6;
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 3; a++) begin
                full_frame(sweep_addr[a], ratios[r], cap);
                check($sformatf("sweep_r%0d_a%0d", ratios[r], a), 32'(cap), 32'(samp_tbl[prev]));
                prev = sweep_addr[a];
            end
            check($sformatf("sweep_r%0d_ch", ratios[r]), 32'(ch), 32'h7);
        end
        check("sweep_no_err", 32'(err_cnt - e0), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable model of the 8-channel, 12-bit serial ADC that sits on the far end of our ADC SPI link. It lets the frequency-estimator datapath run on boards or benches without the physical converter. The block oversamples the master's SCLK/CS_n/DIN with the system clock and decodes the 3-bit channel address. It requests a sample for that channel from an external source, and shifts it out on DOUT with the converter's frame format and pipeline behaviour.

## Interface
Parameters:
- DATA_W, 12, sample width
- FRAME_BITS, 16, SCLK cycles per frame
- SYNC_STAGES, 2, synchronizer depth on SCLK/CS_n/DIN

Ports:
- iCLK  in  1  system clock; must be ≥ 8× SCLK frequency
- iRST  in  1  reset, asynchronous, active-low
- iSCLK  in  1  SPI clock from master; idles high
- iCS_n  in  1  chip select from master, active-low
- iDIN  in  1  serial address from master
- oDOUT  out  1  serial sample to master
- oDOUT_OE  out  1  high while a frame is active; board logic uses it to tri-state DOUT
- oCH  out  3  channel whose sample is being (or will next be) shifted out
- iSAMPLE  in  DATA_W  sample value for oCH; valid ≤ 1 iCLK after oCH changes
- oRX_ADDR  out  3  address decoded in the last completed frame
- oFRAME_DONE  out  1  one-cycle pulse after the 16th SCLK rising edge
- oFRAME_ERR  out  1  one-cycle pulse when CS_n rises mid-frame

## Operation
- Synchronize iSCLK, iCS_n and iDIN through SYNC_STAGES flops. Detect SCLK rise and fall, and CS_n fall and rise, from the last two synchronized samples.
- State machine:
  - IDLE → ACTIVE on CS_n fall. At that transition:
    - bit counter = 0
    - shift register = {4'b0, iSAMPLE}
    - oDOUT = 0 (MSB of shift register)
    - oDOUT_OE = 1
  - ACTIVE → IDLE on CS_n rise:
    - oDOUT_OE = 0
    - oDOUT = 0
- SCLK rising edge in ACTIVE:
  - At counter values 2, 3, 4 (value before increment), capture iDIN into addr_next[2], [1], [0].
  - Increment the counter.
- SCLK falling edge in ACTIVE: shift left and drive the new MSB on oDOUT.
  - Exception: the falling edge after counter reaches FRAME_BITS reloads {4'b0, iSAMPLE} and resets the counter to 0 (continuous mode, CS_n held low).
- Frame complete (16th rising edge):
  - oCH ← addr_next
  - oRX_ADDR ← addr_next
  - oFRAME_DONE pulses
- Conversion pipeline: the sample output in frame N belongs to the address received in frame N−1. After reset the first frame returns channel 0.
- Abort: CS_n rises with counter in 1..15:
  - oFRAME_ERR pulses
  - oCH, oRX_ADDR and addr_next are unchanged
  - counter is cleared
  - CS_n rising with counter 0 is not an error.
- SCLK edges while CS_n is high are ignored.
- If CS_n rises and the 16th rising edge completes in the same iCLK cycle, the completion wins: oFRAME_DONE pulses and oFRAME_ERR does not.
- Reset values:
  - oDOUT 0, oDOUT_OE 0, oCH 0, oRX_ADDR 0, oFRAME_DONE 0, oFRAME_ERR 0
  - state IDLE, counter 0, shift register 0
  - Reset mid-frame returns to IDLE immediately. A new frame starts only on the next CS_n fall.

## Timing
- Input-to-detect latency: SYNC_STAGES+1 iCLK cycles (3 at default).
- oDOUT updates 1 iCLK after the falling-edge detect, i.e. ≤ 4 iCLK after the physical SCLK fall. At 8× oversampling this leaves ≥ 0 iCLK of margin before the master samples on the rising edge.
- oCH updates on the completion cycle. iSAMPLE is loaded at the next falling edge, ≥ 3 iCLK later, so a registered (1-cycle) sample source is allowed.
- oFRAME_DONE and oFRAME_ERR are single-cycle registered pulses.

## Structure
- Package adc_spi_pkg holds:
  - FRAME_BITS
  - LEAD_ZEROS = 4
  - address bit positions ADDR_POS2/1/0 = 2/3/4
  - the state enum {IDLE, ACTIVE}
- Sub-module sync_edge_det: SYNC_STAGES-flop synchronizer with rise/fall outputs. It is instantiated for iSCLK and iCS_n; iDIN uses its synchronized output only.

## Test plan
- Reset, master frame with address 5, iSAMPLE = 12'hABC for ch0 → DOUT bits 0000_1010_1011_1100; oFRAME_DONE pulses once; oCH = 5; oRX_ADDR = 5.
- Next frame with address 2, source returns 12'h123 for ch5 → DOUT 0000_0001_0010_0011; oCH = 2 afterwards.
- CS_n raised after 9 SCLK cycles → oFRAME_ERR pulses; oCH stays at its prior value; next full frame is correct.
- CS_n held low for 32 SCLK cycles with addresses 3 then 7 → two oFRAME_DONE pulses; second 16 bits carry the ch3 sample; final oCH = 7.
- iRST asserted at SCLK 8 of a frame → all outputs 0 within the reset; a following full frame returns the ch0 sample.
- Sweep iCLK:SCLK ratio 8, 9, 16 with random samples and addresses → master-side capture matches the expected pipeline; no errors.
